// File: rtl/synth_pkg.sv
// Shared types and constants for the voice mixer: voice count, Q.20 unity,
// waveform and FSM state encodings, and the 16-bit signed sample type.
package synth_pkg;

  localparam int unsigned VOICES  = 8;
  localparam logic [31:0] Q20_ONE = 32'h0010_0000;

  typedef enum logic [1:0] {
    WAVE_SQUARE,
    WAVE_SAW,
    WAVE_TRI,
    WAVE_OFF
  } wave_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    ACC,
    OUT
  } mixer_state_t;

  typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/wave_shaper.sv
// Combinational waveform generator: maps the top phase bits p[31:15] of one
// voice to a full-scale signed sample for the selected waveform.
module wave_shaper
  import synth_pkg::*;
(
  input  logic [16:0] phase_i,
  input  wave_t       wave_i,
  output sample_t     wave_o
);

  logic [15:0] fold;

  // Ramp p[30:15] up in the first half-cycle and back down in the second.
  assign fold = phase_i[16] ? ~phase_i[15:0] : phase_i[15:0];

  always_comb begin
    wave_o = '0;
    unique case (wave_i)
      WAVE_SQUARE: wave_o = phase_i[16] ? 16'sh8000 : 16'sh7fff;
      WAVE_SAW:    wave_o = {~phase_i[16], phase_i[15:1]};
      WAVE_TRI:    wave_o = {~fold[15], fold[14:0]};
      default:     wave_o = '0;
    endcase
  end

endmodule

// File: rtl/voice_mixer.sv
// Time-multiplexed additive mixer: one phase accumulator per voice, scaled by
// the voice volume and summed into one saturated 16-bit sample per audio tick.
module voice_mixer
  import synth_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned SAMPLE_HZ   = 48000,
  parameter int unsigned VOICES      = synth_pkg::VOICES,
  parameter logic [31:0] PHASE_SCALE = 32'd366503876,
  parameter int unsigned MIX_SHIFT   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [VOICES-1:0][31:0] frequencies,
  input  logic [VOICES-1:0][31:0] voice_volumes,
  input  logic [1:0]              wave_sel,
  output sample_t                 sample,
  output logic                    sample_valid,
  output logic                    busy,
  output mixer_state_t            dbg_state
);

  localparam int unsigned DIV = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned VW  = (VOICES > 1) ? $clog2(VOICES) : 1;

  logic [CW-1:0]      cnt_q;
  logic               tick;
  mixer_state_t       state_q, state_d;
  logic [VW-1:0]      v_q, v_d;
  logic [31:0]        phase_q     [VOICES];
  logic [31:0]        freq_snap_q [VOICES];
  logic [31:0]        vol_snap_q  [VOICES];
  wave_t              wave_q;
  sample_t            wave_val_q, wave_val_d, shaped, sample_q, sample_d, sat;
  logic signed [16:0] prod_q, prod_d;
  logic signed [19:0] acc_q, acc_d, mix;
  logic               valid_q, valid_d, busy_q, busy_d, phase_we;
  logic [31:0]        cur_phase, cur_freq, cur_vol, inc;
  logic [63:0]        inc_full;
  logic [20:0]        vol_c;
  logic signed [36:0] mprod;
  logic               unused_bits;

  assign tick      = (cnt_q == CW'(DIV - 1));
  assign cur_phase = phase_q[v_q];
  assign cur_freq  = freq_snap_q[v_q];
  assign cur_vol   = vol_snap_q[v_q];
  assign inc_full  = 64'(cur_freq) * 64'(PHASE_SCALE);
  assign inc       = inc_full[63:32];

  wave_shaper u_shaper (
    .phase_i (cur_phase[31:15]),
    .wave_i  (wave_q),
    .wave_o  (shaped)
  );

  // Volume is only meaningful in [0, 1.0]; anything outside is pinned.
  always_comb begin
    if (cur_vol[31])             vol_c = '0;
    else if (cur_vol > Q20_ONE)  vol_c = 21'(Q20_ONE);
    else                         vol_c = cur_vol[20:0];
  end

  assign mprod = 37'(wave_val_q) * 37'($signed({1'b0, vol_c}));
  assign mix   = acc_q >>> MIX_SHIFT;

  always_comb begin
    if (mix > 20'sd32767)       sat = 16'sh7fff;
    else if (mix < -20'sd32768) sat = 16'sh8000;
    else                        sat = mix[15:0];
  end

  assign unused_bits = ^{inc_full[31:0], mprod[19:0], cur_phase[14:0]};

  always_comb begin
    state_d    = state_q;
    v_d        = v_q;
    acc_d      = acc_q;
    wave_val_d = wave_val_q;
    prod_d     = prod_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    phase_we   = 1'b0;
    unique case (state_q)
      IDLE: state_d = IDLE;
      LOAD: begin
        wave_val_d = shaped;
        phase_we   = 1'b1;
        state_d    = MUL;
      end
      MUL: begin
        prod_d  = mprod[36:20];
        state_d = ACC;
      end
      ACC: begin
        acc_d = acc_q + 20'(prod_q);
        if (v_q == VW'(VOICES - 1)) begin
          state_d = OUT;
        end else begin
          v_d     = v_q + 1'b1;
          state_d = LOAD;
        end
      end
      OUT: begin
        sample_d = sat;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (tick) begin
      state_d = LOAD;
      v_d     = '0;
      acc_d   = '0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      state_q    <= IDLE;
      v_q        <= '0;
      acc_q      <= '0;
      wave_val_q <= '0;
      prod_q     <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      wave_q     <= WAVE_OFF;
      for (int i = 0; i < VOICES; i++) begin
        phase_q[i]     <= '0;
        freq_snap_q[i] <= '0;
        vol_snap_q[i]  <= '0;
      end
    end else begin
      cnt_q      <= tick ? '0 : cnt_q + 1'b1;
      state_q    <= state_d;
      v_q        <= v_d;
      acc_q      <= acc_d;
      wave_val_q <= wave_val_d;
      prod_q     <= prod_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      if (phase_we) phase_q[v_q] <= cur_phase + inc;
      if (tick) begin
        wave_q <= wave_t'(wave_sel);
        for (int i = 0; i < VOICES; i++) begin
          freq_snap_q[i] <= frequencies[i];
          vol_snap_q[i]  <= voice_volumes[i];
        end
      end
    end
  end

  // A new tick must never land on a frame still in progress.
  tick_while_busy: assert property (@(posedge clk) disable iff (reset) !(tick && busy_q));

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
- Downstream stage of the keyboard voice allocator.
- Consumes per-voice frequency (Hz, Q12.20) and volume (Q.20, 1<<20 = full scale) arrays.
- Runs one phase-accumulator oscillator per voice, scales each voice by its volume, and sums all voices into one signed 16-bit mono sample per audio tick.
- Feeds the audio output/DAC interface of the core.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- SAMPLE_HZ, 48000, target sample rate. DIV = CLK_HZ/SAMPLE_HZ (integer, truncated). DIV must be > 3*VOICES+2.
- VOICES, 8, number of voices. Must match the allocator's TOP_VOICE+1.
- PHASE_SCALE, 366503876, round(2^44 / actual sample rate). The actual sample rate is CLK_HZ/DIV; the default assumes the nominal rate.
- MIX_SHIFT, 3, arithmetic right shift applied to the voice sum before saturation.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- frequencies, in, VOICES x 32, per-voice frequency, unsigned Q12.20 Hz.
- voice_volumes, in, VOICES x 32, per-voice volume, signed Q.20.
- wave_sel, in, 2, waveform: 0 square, 1 saw, 2 triangle, 3 silence.
- sample, out, 16, signed mixed sample.
- sample_valid, out, 1, one-cycle pulse when `sample` updates.
- busy, out, 1, high while a frame is being computed.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset:
  - all phase accumulators = 0, tick counter = 0, state = IDLE;
  - sample = 0, sample_valid = 0, busy = 0.
- Tick counter: counts 0..DIV-1 and wraps. At count DIV-1, tick = 1 for one cycle.
  - Ticks are exactly DIV cycles apart regardless of compute state.
  - The counter runs even while busy.
- Snapshot: on a tick, latch frequencies, voice_volumes and wave_sel into internal registers, clear the accumulator, set busy, and enter LOAD with voice index v = 0.
  - Input changes during a frame have no effect until the next tick.
- State machine: IDLE -> LOAD -> MUL -> ACC -> (v < VOICES-1 ? LOAD with v+1 : OUT) -> IDLE.
  - LOAD: read phase[v].
    - Wave from the phase top bits p[31:16]:
      - square = p[31] ? -32768 : 32767.
      - saw = p[31:16] with MSB inverted, read as signed.
      - triangle = fold of p[30:15] with sign from p[31], mapped onto -32768..32767.
      - silence = 0.
    - Increment: inc = (freq_snap[v] * PHASE_SCALE) >> 32, using a 64-bit product and 32-bit result.
    - phase[v] <= phase[v] + inc, mod 2^32. Wrap is natural; the phase is never reset by note changes.
  - MUL: clamp the volume. Negative -> 0; > (1<<20) -> (1<<20). Then prod = (wave * vol_clamped) >>> 20, a signed 17-bit result.
  - ACC: acc <= acc + prod. acc is signed 20-bit, which cannot overflow for 8 voices.
  - OUT:
    - m = acc >>> MIX_SHIFT, saturated to [-32768, 32767];
    - sample <= m; sample_valid = 1 for this cycle only; busy <= 0.
- Latency: tick to sample_valid = 3*VOICES+1 cycles (25 at default).
- A phase uses the pre-increment value for its output. The first sample after reset therefore reads phase 0.
- frequency = 0: the phase holds, and the output is the constant wave value at that phase times volume.
- Tick arriving while busy: cannot occur given the DIV constraint. The implementation must assert on it in simulation.
- Reset mid-frame: the frame is abandoned, no sample_valid is emitted, and the next tick is DIV cycles after reset release.

Decomposition:
- Package synth_pkg:
  - VOICES;
  - Q20_ONE = 1<<20;
  - wave_t enum (WAVE_SQUARE, WAVE_SAW, WAVE_TRI, WAVE_OFF);
  - mixer_state_t enum (IDLE, LOAD, MUL, ACC, OUT);
  - sample_t = signed 16-bit.
- One sub-module, wave_shaper: combinational, phase[31:15] + wave_t -> sample_t. Instantiated once, since voices are time-multiplexed.
- Phase registers are held in a small array inside voice_mixer.

Test Plan:
1. Reset with all volumes 0: sample stays 0, and sample_valid pulses every 1041 cycles (CLK_HZ 50e6, SAMPLE_HZ 48000), first pulse 1041+25 cycles after reset release.
2. Voice 0: freq 440<<20, vol 1<<20, square, others 0. Samples alternate between 4095 and -4096, half-period ~54-55 samples; phase increment = 39370534 ±1.
3. All 8 voices: freq 440<<20, vol 1<<20, square, MIX_SHIFT=0. Sample saturates to exactly 32767 and -32768.
4. Voice 0 vol = -5 -> contributes 0. Vol = 2<<20 -> identical output to vol = 1<<20. Vol = 1<<19 -> square 2047/-2048 at MIX_SHIFT 3.
5. Change frequencies mid-frame (10 cycles after tick): the current sample uses old values, and the next frame uses new ones with a continuous phase (no jump back to 0).
6. Assert reset 12 cycles into a frame: no sample_valid for that frame, sample = 0 next cycle, all phases 0, next valid at 1041+25 cycles after release.
